// File: rtl/debounce_multi.sv
// debounce_multi: per-channel button conditioner with a two-flop synchroniser and a debounce window.
// It also produces press, release and long-press pulses.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 5000,
    parameter int LONG_CYCLES   = 100000,
    parameter bit ACTIVE_LOW_IN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_p,
    output logic            any_press
);
    localparam int DW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);

    logic [N_CH-1:0] pin;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    // Polarity is corrected before the synchroniser so reset means "released".
    assign pin = ACTIVE_LOW_IN ? ~btn : btn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold_cnt;
        logic          lvl;
        logic          pr;
        logic          rl;
        logic          lp;
        logic          flip;
        logic          fall;

        assign flip = (sync2[i] != lvl) && (db_cnt == DB_LAST);
        assign fall = flip && lvl;

        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
                pr     <= 1'b0;
                rl     <= 1'b0;
            end else begin
                pr <= flip && !lvl;
                rl <= fall;
                if (sync2[i] == lvl) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    lvl    <= sync2[i];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // A release finishing on the firing cycle suppresses the long pulse.
        always_ff @(posedge clk) begin
            if (!rst) begin
                hold_cnt <= '0;
                lp       <= 1'b0;
            end else begin
                lp <= 1'b0;
                if (!lvl || fall) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= HOLD_DONE;
                    lp       <= 1'b1;
                end else if (hold_cnt != HOLD_DONE) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end

        assign level[i]     = lvl;
        assign press_p[i]   = pr;
        assign release_p[i] = rl;
        assign long_p[i]    = lp;
    end

    assign any_press = |press_p;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scoreboard bench for debounce_multi.
// It drives one active-high instance and one active-low instance.
module tb_debounce_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a;
    logic [1:0] btn_b;
    logic [1:0] level_a, press_a, rel_a, long_a;
    logic [1:0] level_b, press_b, rel_b, long_b;
    logic       any_a, any_b;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(2), .DB_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW_IN(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .btn(btn_a),
        .level(level_a), .press_p(press_a), .release_p(rel_a),
        .long_p(long_a), .any_press(any_a)
    );

    debounce_multi #(
        .N_CH(2), .DB_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW_IN(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .level(level_b), .press_p(press_b), .release_p(rel_b),
        .long_p(long_b), .any_press(any_b)
    );

    typedef struct {
        string      tag;
        logic [8:0] ea;
        logic [8:0] eb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expectation word: {level, press, release, long}; any_press is the OR of press.
    localparam logic [7:0] Z = 8'b00_00_00_00;

    function automatic logic [8:0] x9(input logic [7:0] e);
        return {e, |e[5:4]};
    endfunction

    task automatic cyc(input string tag, input int n,
                       input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        exp_t got;
        logic [8:0] oa;
        logic [8:0] ob;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.ea  = x9(ea);
            e.eb  = x9(eb);
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            oa  = {level_a, press_a, rel_a, long_a, any_a};
            ob  = {level_b, press_b, rel_b, long_b, any_b};
            checks++;
            assert (oa === got.ea) else begin
                errors++;
                $error("FAIL %s[%0d] dut_a: observed %b expected %b",
                       got.tag, i, oa, got.ea);
            end
            checks++;
            assert (ob === got.eb) else begin
                errors++;
                $error("FAIL %s[%0d] dut_b: observed %b expected %b",
                       got.tag, i, ob, got.eb);
            end
        end
    endtask

    initial begin
        logic [7:0] e;
        rst   = 1'b0;
        btn_a = 2'b00;
        btn_b = 2'b11;
        cyc("reset", 2, Z, Z);
        rst = 1'b1;

        // Clean press, long press, release
        btn_a = 2'b01;
        cyc("press_wait", 5, Z, Z);
        cyc("press_pulse", 1, 8'b01_01_00_00, Z);
        cyc("held", 9, 8'b01_00_00_00, Z);
        cyc("long_pulse", 1, 8'b01_00_00_01, Z);
        cyc("held_after_long", 1, 8'b01_00_00_00, Z);
        btn_a = 2'b00;
        cyc("rel_wait", 5, 8'b01_00_00_00, Z);
        cyc("rel_pulse", 1, 8'b00_00_01_00, Z);
        cyc("idle1", 2, Z, Z);

        // Glitch of three samples
        btn_a = 2'b01;
        cyc("glitch_hi", 3, Z, Z);
        btn_a = 2'b00;
        cyc("glitch_lo", 6, Z, Z);

        // Short press
        btn_a = 2'b01;
        cyc("short_wait", 5, Z, Z);
        cyc("short_pulse", 1, 8'b01_01_00_00, Z);
        cyc("short_held", 1, 8'b01_00_00_00, Z);
        btn_a = 2'b00;
        cyc("short_rel_wait", 5, 8'b01_00_00_00, Z);
        cyc("short_rel_pulse", 1, 8'b00_00_01_00, Z);
        cyc("short_idle", 12, Z, Z);

        // Release lands on the cycle long_p would fire
        btn_a = 2'b01;
        cyc("rw_wait", 5, Z, Z);
        cyc("rw_pulse", 1, 8'b01_01_00_00, Z);
        cyc("rw_held", 4, 8'b01_00_00_00, Z);
        btn_a = 2'b00;
        cyc("rw_rel_wait", 5, 8'b01_00_00_00, Z);
        cyc("rw_rel_pulse", 1, 8'b00_00_01_00, Z);
        cyc("rw_idle", 3, Z, Z);

        // Simultaneous channels
        btn_a = 2'b11;
        cyc("sim_wait", 5, Z, Z);
        cyc("sim_pulse", 1, 8'b11_11_00_00, Z);
        cyc("sim_held", 1, 8'b11_00_00_00, Z);
        btn_a = 2'b00;
        cyc("sim_rel_wait", 5, 8'b11_00_00_00, Z);
        cyc("sim_rel_pulse", 1, 8'b00_00_11_00, Z);
        cyc("sim_idle", 2, Z, Z);

        // Channel 1 bounces every 2 cycles while channel 0 presses
        for (int i = 0; i < 10; i++) begin
            btn_a = {((i % 4) < 2) ? 1'b1 : 1'b0, 1'b1};
            if (i < 5)
                e = Z;
            else if (i == 5)
                e = 8'b01_01_00_00;
            else
                e = 8'b01_00_00_00;
            cyc("bounce", 1, e, Z);
        end
        btn_a = 2'b00;
        cyc("bounce_rel_wait", 5, 8'b01_00_00_00, Z);
        cyc("bounce_rel_pulse", 1, 8'b00_00_01_00, Z);
        cyc("bounce_idle", 3, Z, Z);

        // Reset while pressed, button still held afterwards
        btn_a = 2'b01;
        cyc("rm_wait", 5, Z, Z);
        cyc("rm_pulse", 1, 8'b01_01_00_00, Z);
        cyc("rm_held", 1, 8'b01_00_00_00, Z);
        rst = 1'b0;
        cyc("reset_mid", 1, Z, Z);
        rst = 1'b1;
        cyc("rearm_wait", 5, Z, Z);
        cyc("rearm_pulse", 1, 8'b01_01_00_00, Z);
        btn_a = 2'b00;
        cyc("rearm_rel_wait", 5, 8'b01_00_00_00, Z);
        cyc("rearm_rel_pulse", 1, 8'b00_00_01_00, Z);
        cyc("rearm_idle", 2, Z, Z);

        // Active-low instance: channel 0 pin pulled low
        btn_b = 2'b10;
        cyc("al_wait", 5, Z, Z);
        cyc("al_pulse", 1, Z, 8'b01_01_00_00);
        cyc("al_held", 1, Z, 8'b01_00_00_00);
        btn_b = 2'b11;
        cyc("al_rel_wait", 5, Z, 8'b01_00_00_00);
        cyc("al_rel_pulse", 1, Z, 8'b00_00_01_00);
        cyc("al_idle", 2, Z, Z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
